// File: rtl/param_editor.sv
// param_editor
//   Button-driven editor for the five waveform parameters shown on the 4-digit
//   7-segment display. Debounced button levels become press events (rising
//   edges, plus auto-repeat for up/down). A decimal-digit cursor selects the
//   step, and up/down add or subtract 10^cursor with saturation at the limits
//   of the active parameter.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   btn_up/down       increment / decrement the digit under the cursor
//   btn_left/right    move the cursor to a more / less significant digit
//   btn_center        advance to the next mode
//   value             active parameter, zero-extended (to the display)
//   mode              0 freq, 1 phase, 2 duty, 3 sweep range, 4 sweep speed
//   cursor            digit under edit, 0 = units
//   freq_val .. sweep_speed   parameter registers (to the waveform core)
//   param_changed     one-cycle pulse after a parameter register changed
module param_editor #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [19:0] value,
  output logic [3:0]  mode,
  output logic [2:0]  cursor,
  output logic [19:0] freq_val,
  output logic [8:0]  phase_val,
  output logic [6:0]  duty_val,
  output logic [13:0] sweep_range,
  output logic [13:0] sweep_speed,
  output logic        param_changed
);

  localparam int NBTN     = 5;
  localparam int B_DOWN   = 0;
  localparam int B_UP     = 1;
  localparam int B_RIGHT  = 2;
  localparam int B_LEFT   = 3;
  localparam int B_CENTER = 4;

  // hold_cnt runs 1..HOLD_LAST and then folds back to HOLD_FIRST, so it sits
  // on HOLD_FIRST once after REPEAT_DELAY and then every REPEAT_PERIOD.
  localparam logic [31:0] HOLD_FIRST = 32'(REPEAT_DELAY);
  localparam logic [31:0] HOLD_LAST  = 32'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] live;
  logic [NBTN-1:0] rise;

  assign btn = {btn_center, btn_left, btn_right, btn_up, btn_down};

  // Per-button history. 'armed' only sets once the button has been seen low,
  // so a button held through reset cannot act (or auto-repeat) until it is
  // released and pressed again.
  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic prev_reg;
      logic armed_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prev_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          prev_reg  <= btn[gi];
          armed_reg <= armed_reg | ~btn[gi];
        end
      end
      assign live[gi] = btn[gi] & armed_reg;
      assign rise[gi] = live[gi] & ~prev_reg;
    end
  endgenerate

  // Auto-repeat bookkeeping: only while exactly one of up/down is held.
  logic [31:0] hold_cnt;
  logic        hold_active;
  logic        hold_fresh;
  logic        repeat_hit;

  assign hold_active = live[B_UP] ^ live[B_DOWN];
  assign hold_fresh  = rise[B_UP] | rise[B_DOWN];
  assign repeat_hit  = hold_active && !hold_fresh && (hold_cnt == HOLD_FIRST);

  // Priority resolution: center > left > right > up > down.
  logic up_req, down_req;
  logic ev_center, ev_left, ev_right, ev_up, ev_down;

  assign up_req    = rise[B_UP]   | (repeat_hit & live[B_UP]);
  assign down_req  = rise[B_DOWN] | (repeat_hit & live[B_DOWN]);
  assign ev_center = rise[B_CENTER];
  assign ev_left   = rise[B_LEFT]  & ~rise[B_CENTER];
  assign ev_right  = rise[B_RIGHT] & ~|rise[B_CENTER:B_LEFT];
  assign ev_up     = up_req & ~|rise[B_CENTER:B_RIGHT];
  assign ev_down   = down_req & ~up_req & ~|rise[B_CENTER:B_RIGHT];

  // Active parameter and its limits. An illegal mode falls back to the
  // frequency view so value shows freq_val while the mode recovers.
  logic [20:0] cur_p;
  logic [20:0] p_min;
  logic [20:0] p_max;
  logic [2:0]  last_digit;
  logic        mode_ok;

  always_comb begin
    cur_p      = {1'b0, freq_val};
    p_min      = 21'd1;
    p_max      = 21'd999999;
    last_digit = 3'd5;
    mode_ok    = 1'b1;
    case (mode)
      4'd0: ;
      4'd1: begin
        cur_p = {12'd0, phase_val}; p_min = 21'd0; p_max = 21'd359; last_digit = 3'd2;
      end
      4'd2: begin
        cur_p = {14'd0, duty_val}; p_min = 21'd0; p_max = 21'd100; last_digit = 3'd2;
      end
      4'd3: begin
        cur_p = {7'd0, sweep_range}; p_min = 21'd0; p_max = 21'd9999; last_digit = 3'd3;
      end
      4'd4: begin
        cur_p = {7'd0, sweep_speed}; p_min = 21'd1; p_max = 21'd9999; last_digit = 3'd3;
      end
      default: mode_ok = 1'b0;
    endcase
  end

  logic [20:0] step;

  always_comb begin
    case (cursor)
      3'd0:    step = 21'd1;
      3'd1:    step = 21'd10;
      3'd2:    step = 21'd100;
      3'd3:    step = 21'd1000;
      3'd4:    step = 21'd10000;
      3'd5:    step = 21'd100000;
      default: step = 21'd1;
    endcase
  end

  // 21-bit arithmetic: largest sum is 999999 + 100000, well inside range.
  logic [20:0] sum_p;
  logic [20:0] new_p;

  always_comb begin
    sum_p = cur_p + step;
    if (ev_up)
      new_p = (sum_p > p_max) ? p_max : sum_p;
    else
      new_p = (cur_p < p_min + step) ? p_min : cur_p - step;
  end

  logic change_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt      <= '0;
      mode          <= 4'd0;
      cursor        <= 3'd0;
      freq_val      <= 20'd1000;
      phase_val     <= 9'd0;
      duty_val      <= 7'd50;
      sweep_range   <= 14'd1000;
      sweep_speed   <= 14'd10;
      value         <= 20'd1000;
      change_pend   <= 1'b0;
      param_changed <= 1'b0;
    end else begin
      if (!hold_active)
        hold_cnt <= '0;
      else if (hold_fresh)
        hold_cnt <= 32'd1;
      else if (hold_cnt == HOLD_LAST)
        hold_cnt <= HOLD_FIRST;
      else
        hold_cnt <= hold_cnt + 32'd1;

      // Display and change pulse trail the register update by one edge.
      value         <= cur_p[19:0];
      param_changed <= change_pend;
      change_pend   <= 1'b0;

      if (!mode_ok) begin
        mode   <= 4'd0;
        cursor <= 3'd0;
      end else if (ev_center) begin
        mode   <= (mode == 4'd4) ? 4'd0 : mode + 4'd1;
        cursor <= 3'd0;
      end else if (ev_left) begin
        if (cursor < last_digit)
          cursor <= cursor + 3'd1;
      end else if (ev_right) begin
        if (cursor != 3'd0)
          cursor <= cursor - 3'd1;
      end else if ((ev_up || ev_down) && (new_p != cur_p)) begin
        change_pend <= 1'b1;
        case (mode)
          4'd0:    freq_val    <= new_p[19:0];
          4'd1:    phase_val   <= new_p[8:0];
          4'd2:    duty_val    <= new_p[6:0];
          4'd3:    sweep_range <= new_p[13:0];
          default: sweep_speed <= new_p[13:0];
        endcase
      end
    end
  end

endmodule
